ahb_req_arbiter: RTL and testbench
==================================

Name: ahb_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single AHB-Lite master between N local requesters.
- Selects one pending request and drives the master's command inputs: enable, wr, addr, dina, dinb, slave_sel.
- Waits for slave completion or timeout, then returns a one-cycle ack with read data and error status to the winning requester.
- Sits between client logic and the AHB master; the master's own protocol is unchanged.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 16, max WAIT cycles before forced error completion (>=2).
- GW, 3, grant-index width; must satisfy 2^GW >= N.

Ports:
- hclk  in  1  clock.
- hresetn  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester request; level, held until ack.
- req_wr  in  N  1=write, 0=read, per requester.
- req_addr  in  32*N  address; requester i uses bits [32i+31:32i].
- req_dina  in  32*N  write operand A, same slicing.
- req_dinb  in  32*N  write operand B, same slicing.
- req_sel  in  2*N  slave select; requester i uses [2i+1:2i].
- gnt  out  N  one-hot grant, high from ADDR through DONE.
- ack  out  N  one-cycle completion pulse to the winner.
- err  out  1  valid with ack; 1 = hresp error or timeout.
- rdata  out  32  read result, valid with ack on reads; held otherwise.
- busy  out  1  high in any state other than IDLE.
- m_enable  out  1  to master enable.
- m_wr  out  1  to master wr.
- m_addr  out  32  to master addr.
- m_dina  out  32  to master dina.
- m_dinb  out  32  to master dinb.
- m_slave_sel  out  2  to master slave_sel.
- m_dout  in  32  master read-data output.
- hreadyout  in  1  slave ready.
- hresp  in  1  slave error response.

Behaviour:
- Reset (async): all outputs 0, state IDLE, last_grant=N-1 (requester 0 has first priority), wait counter 0.
- FSM: IDLE -> ADDR -> WAIT -> DONE -> IDLE. All outputs registered.
- IDLE:
  - req sampled only in this state.
  - If req!=0, the winner is the first set bit searching last_grant+1, +2, ... modulo N.
  - On that edge: latch the winner's wr/addr/dina/dinb/sel into the m_* outputs, set gnt to the one-hot winner, set m_enable=1, go to ADDR.
- ADDR: exactly 1 cycle. Next edge: m_enable=0, counter=0, go to WAIT. m_* command fields stay stable until DONE exits.
- WAIT: each cycle, evaluate in order:
  - hreadyout=1: go to DONE; err<=hresp; if m_wr=0, rdata<=m_dout.
  - Else if counter==TIMEOUT-1: go to DONE; err<=1; rdata unchanged.
  - Else: counter+1.
- DONE: ack[winner]=1 for exactly this cycle with err valid. Next edge: gnt=0, ack=0, err=0, last_grant=winner, go to IDLE.
- Throughput: minimum 4 cycles per transfer (IDLE, ADDR, WAIT, DONE); at least one IDLE cycle between transfers.
- Request withdrawal: a req dropped after grant is ignored; the transfer completes and ack still pulses.
- Simultaneous requests: only one grant at a time; the others wait. A continuously requesting client is served within N transfers (no starvation).
- Requester command inputs change after grant: no effect, since the command is latched in IDLE.
- Reset mid-transfer: immediate return to reset values, no ack issued, the in-flight request is lost.
- Unused high grant indices (2^GW > N) are never selected.

Test Plan:
- Single read: req=4'b0010, req_wr[1]=0, addr1=0x100; hreadyout rises 2 cycles into WAIT with m_dout=0xDEADBEEF -> m_enable pulses 1 cycle with m_addr=0x100, gnt=0010, ack=0010 for 1 cycle, rdata=0xDEADBEEF, err=0.
- Round-robin: all four req held high, hreadyout=1 -> ack order 0,1,2,3,0. Each gnt is one-hot. Requests are spaced exactly 4 cycles.
- Write with error: requester 2 writes dina=5, dinb=7, sel=2'b10; hresp=1 with hreadyout -> m_dina=5, m_dinb=7, m_slave_sel=10, m_wr=1; ack[2] with err=1; rdata unchanged.
- Timeout: hreadyout held 0 -> DONE after 16 WAIT cycles, ack with err=1, busy falls the cycle after ack.
- Withdrawal and reset: requester 3 drops req in WAIT -> ack[3] still pulses. Assert hresetn=0 during a later WAIT -> all outputs 0 immediately, no ack; after release, requester 0 wins first.

Source files
------------

// File: rtl/ahb_req_arbiter_if.sv
// Requester-side command bus and AHB-master-side command/response bus for ahb_req_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/master view.
interface ahb_req_arbiter_if #(
    parameter int unsigned N = 4
);
    // Requester side
    logic [N-1:0]      req;
    logic [N-1:0]      req_wr;
    logic [32*N-1:0]   req_addr;
    logic [32*N-1:0]   req_dina;
    logic [32*N-1:0]   req_dinb;
    logic [2*N-1:0]    req_sel;
    logic [N-1:0]      gnt;
    logic [N-1:0]      ack;
    logic              err;
    logic [31:0]       rdata;
    logic              busy;
    // AHB master side
    logic              m_enable;
    logic              m_wr;
    logic [31:0]       m_addr;
    logic [31:0]       m_dina;
    logic [31:0]       m_dinb;
    logic [1:0]        m_slave_sel;
    logic [31:0]       m_dout;
    logic              hreadyout;
    logic              hresp;

    modport slave (
        input  req, req_wr, req_addr, req_dina, req_dinb, req_sel,
        input  m_dout, hreadyout, hresp,
        output gnt, ack, err, rdata, busy,
        output m_enable, m_wr, m_addr, m_dina, m_dinb, m_slave_sel
    );

    modport master (
        output req, req_wr, req_addr, req_dina, req_dinb, req_sel,
        output m_dout, hreadyout, hresp,
        input  gnt, ack, err, rdata, busy,
        input  m_enable, m_wr, m_addr, m_dina, m_dinb, m_slave_sel
    );
endinterface

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter that shares one AHB-Lite master between N requesters.
// One transfer at a time: IDLE (arbitrate) -> ADDR -> WAIT (ready or timeout) -> DONE (ack).
module ahb_req_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned GW      = 3
) (
    input  logic            hclk,
    input  logic            hresetn,
    ahb_req_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StAddr, StWait, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic [GW-1:0]   r_last, w_last_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic [N-1:0]    r_ack, w_ack_nxt;
    logic            r_err, w_err_nxt;
    logic [31:0]     r_rdata, w_rdata_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_en, w_en_nxt;
    logic            r_wr, w_wr_nxt;
    logic [31:0]     r_addr, w_addr_nxt;
    logic [31:0]     r_dina, w_dina_nxt;
    logic [31:0]     r_dinb, w_dinb_nxt;
    logic [1:0]      r_sel, w_sel_nxt;

    // Winner selection and its command fields
    logic [GW-1:0]   w_win_hi, w_win_lo, w_win;
    logic            w_found_hi;
    logic [N-1:0]    w_onehot;
    logic            w_cmd_wr;
    logic [31:0]     w_cmd_addr, w_cmd_dina, w_cmd_dinb;
    logic [1:0]      w_cmd_sel;

    // Rotating priority: lowest set index above last_grant, else lowest set index overall
    always_comb begin
        w_win_hi   = '0;
        w_win_lo   = '0;
        w_found_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                if (GW'(i) > r_last) begin
                    w_win_hi   = GW'(i);
                    w_found_hi = 1'b1;
                end else begin
                    w_win_lo = GW'(i);
                end
            end
        end
        w_win = w_found_hi ? w_win_hi : w_win_lo;
    end

    // Mux the winner's command slice and build its one-hot grant
    always_comb begin
        w_onehot   = '0;
        w_cmd_wr   = 1'b0;
        w_cmd_addr = '0;
        w_cmd_dina = '0;
        w_cmd_dinb = '0;
        w_cmd_sel  = '0;
        for (int i = 0; i < N; i++) begin
            if (GW'(i) == w_win) begin
                w_onehot[i] = 1'b1;
                w_cmd_wr    = bus.req_wr[i];
                w_cmd_addr  = bus.req_addr[32*i +: 32];
                w_cmd_dina  = bus.req_dina[32*i +: 32];
                w_cmd_dinb  = bus.req_dinb[32*i +: 32];
                w_cmd_sel   = bus.req_sel[2*i +: 2];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;
        w_rdata_nxt = r_rdata;
        w_busy_nxt  = r_busy;
        w_en_nxt    = r_en;
        w_wr_nxt    = r_wr;
        w_addr_nxt  = r_addr;
        w_dina_nxt  = r_dina;
        w_dinb_nxt  = r_dinb;
        w_sel_nxt   = r_sel;
        unique case (r_state)
            StIdle: begin
                if (|bus.req) begin
                    w_state_nxt = StAddr;
                    w_gnt_nxt   = w_onehot;
                    w_busy_nxt  = 1'b1;
                    w_en_nxt    = 1'b1;
                    w_wr_nxt    = w_cmd_wr;
                    w_addr_nxt  = w_cmd_addr;
                    w_dina_nxt  = w_cmd_dina;
                    w_dinb_nxt  = w_cmd_dinb;
                    w_sel_nxt   = w_cmd_sel;
                end
            end
            StAddr: begin
                w_state_nxt = StWait;
                w_en_nxt    = 1'b0;
                w_cnt_nxt   = '0;
            end
            StWait: begin
                if (bus.hreadyout) begin
                    w_state_nxt = StDone;
                    w_ack_nxt   = r_gnt;
                    w_err_nxt   = bus.hresp;
                    if (!r_wr) begin
                        w_rdata_nxt = bus.m_dout;
                    end
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = StDone;
                    w_ack_nxt   = r_gnt;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
                w_ack_nxt   = '0;
                w_err_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
                w_last_nxt  = w_gnt_to_idx(r_gnt);
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    function automatic logic [GW-1:0] w_gnt_to_idx(input logic [N-1:0] oh);
        logic [GW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = GW'(i);
            end
        end
        return idx;
    endfunction

    // State and output registers; reset aborts any in-flight transfer
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= StIdle;
            r_last  <= GW'(N - 1);
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_dina  <= '0;
            r_dinb  <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
            r_busy  <= w_busy_nxt;
            r_en    <= w_en_nxt;
            r_wr    <= w_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_dina  <= w_dina_nxt;
            r_dinb  <= w_dinb_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.ack         = r_ack;
    assign bus.err         = r_err;
    assign bus.rdata       = r_rdata;
    assign bus.busy        = r_busy;
    assign bus.m_enable    = r_en;
    assign bus.m_wr        = r_wr;
    assign bus.m_addr      = r_addr;
    assign bus.m_dina      = r_dina;
    assign bus.m_dinb      = r_dinb;
    assign bus.m_slave_sel = r_sel;
endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Self-checking bench for ahb_req_arbiter: directed and randomized transfers against a
// transaction-level model of round-robin order, latching, completion and timeout.
module tb_ahb_req_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic hclk = 1'b0;
    logic hresetn;
    always #5 hclk = ~hclk;

    ahb_req_arbiter_if #(.N(N)) bus ();

    ahb_req_arbiter #(.N(N), .TIMEOUT(TO), .GW(3)) u_dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state: who was served last, and the last read result
    int          exp_last;
    logic [31:0] exp_rdata;

    // Per-requester command values driven onto the bus
    logic [N-1:0] c_req;
    logic         c_wr   [N];
    logic [31:0]  c_addr [N];
    logic [31:0]  c_dina [N];
    logic [31:0]  c_dinb [N];
    logic [1:0]   c_sel  [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req = c_req;
        for (int i = 0; i < N; i++) begin
            bus.req_wr[i]           = c_wr[i];
            bus.req_addr[32*i +: 32] = c_addr[i];
            bus.req_dina[32*i +: 32] = c_dina[i];
            bus.req_dinb[32*i +: 32] = c_dinb[i];
            bus.req_sel[2*i +: 2]    = c_sel[i];
        end
    endtask

    task automatic randomize_cmd(input int i);
        c_wr[i]   = 1'($urandom_range(0, 1));
        c_addr[i] = $urandom;
        c_dina[i] = $urandom;
        c_dinb[i] = $urandom;
        c_sel[i]  = 2'($urandom_range(0, 3));
    endtask

    // First pending requester after the last one served, wrapping modulo N
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 0);
        chk({tag, "_ack"}, 32'(bus.ack), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_men"}, 32'(bus.m_enable), 0);
        chk({tag, "_mwr"}, 32'(bus.m_wr), 0);
        chk({tag, "_maddr"}, bus.m_addr, 0);
        chk({tag, "_mdina"}, bus.m_dina, 0);
        chk({tag, "_mdinb"}, bus.m_dinb, 0);
        chk({tag, "_msel"}, 32'(bus.m_slave_sel), 0);
    endtask

    // One transfer, entered while the DUT is in IDLE with c_req already driven.
    // d: WAIT cycles before hreadyout; timeout: never assert hreadyout.
    task automatic xfer(input int d, input bit timeout, input bit rsp_err,
                        input logic [31:0] dout, input bit drop_early, input bit keep);
        int           w;
        logic [N-1:0] oh;
        logic         ew;
        logic [31:0]  ea, eda, edb;
        logic [1:0]   es;
        bit           exp_err;
        w   = pick(c_req, exp_last);
        oh  = N'(1) << w;
        ew  = c_wr[w];
        ea  = c_addr[w];
        eda = c_dina[w];
        edb = c_dinb[w];
        es  = c_sel[w];
        step();
        chk("grant_gnt", 32'(bus.gnt), 32'(oh));
        chk("grant_men", 32'(bus.m_enable), 1);
        chk("grant_maddr", bus.m_addr, ea);
        chk("grant_mwr", 32'(bus.m_wr), 32'(ew));
        chk("grant_mdina", bus.m_dina, eda);
        chk("grant_mdinb", bus.m_dinb, edb);
        chk("grant_msel", 32'(bus.m_slave_sel), 32'(es));
        chk("grant_busy", 32'(bus.busy), 1);
        chk("grant_ack", 32'(bus.ack), 0);
        // Command changes after grant must not reach the master
        c_wr[w]   = ~c_wr[w];
        c_addr[w] = ~ea;
        c_dina[w] = ~eda;
        c_dinb[w] = ~edb;
        c_sel[w]  = ~es;
        if (drop_early) c_req[w] = 1'b0;
        drive();
        step();
        chk("wait_men", 32'(bus.m_enable), 0);
        chk("wait_gnt", 32'(bus.gnt), 32'(oh));
        chk("wait_maddr", bus.m_addr, ea);
        chk("wait_mwr", 32'(bus.m_wr), 32'(ew));
        if (timeout) begin
            for (int c = 0; c < TO; c++) begin
                chk("wait_ack", 32'(bus.ack), 0);
                step();
            end
            exp_err = 1'b1;
        end else begin
            for (int c = 0; c < d; c++) begin
                chk("wait_ack", 32'(bus.ack), 0);
                step();
            end
            bus.hreadyout = 1'b1;
            bus.hresp     = rsp_err;
            bus.m_dout    = dout;
            step();
            bus.hreadyout = 1'b0;
            bus.hresp     = 1'b0;
            bus.m_dout    = $urandom;
            exp_err       = rsp_err;
            if (!ew) exp_rdata = dout;
        end
        chk("done_ack", 32'(bus.ack), 32'(oh));
        chk("done_err", 32'(bus.err), 32'(exp_err));
        chk("done_rdata", bus.rdata, exp_rdata);
        chk("done_gnt", 32'(bus.gnt), 32'(oh));
        chk("done_busy", 32'(bus.busy), 1);
        chk("done_maddr", bus.m_addr, ea);
        if (!keep) c_req[w] = 1'b0;
        randomize_cmd(w);
        drive();
        step();
        chk("idle_ack", 32'(bus.ack), 0);
        chk("idle_gnt", 32'(bus.gnt), 0);
        chk("idle_err", 32'(bus.err), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_men", 32'(bus.m_enable), 0);
        exp_last = w;
    endtask

    initial begin
        hresetn       = 1'b0;
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b0;
        bus.m_dout    = '0;
        c_req         = '0;
        for (int i = 0; i < N; i++) randomize_cmd(i);
        drive();
        exp_last  = N - 1;
        exp_rdata = '0;
        #12;
        chk_all_zero("reset");
        @(negedge hclk);
        hresetn = 1'b1;
        step();

        // No requests: arbiter stays idle
        for (int c = 0; c < 3; c++) begin
            step();
            chk("noreq_busy", 32'(bus.busy), 0);
            chk("noreq_gnt", 32'(bus.gnt), 0);
        end

        // Round-robin with all requesters held, immediate ready: 0,1,2,3,0
        c_req = '1;
        drive();
        for (int t = 0; t < 5; t++) xfer(0, 1'b0, 1'b0, $urandom, 1'b0, 1'b1);
        chk("rr_last", 32'(exp_last), 0);

        // Single read from requester 1, ready two cycles into WAIT
        c_req     = 4'b0010;
        c_wr[1]   = 1'b0;
        c_addr[1] = 32'h0000_0100;
        drive();
        xfer(2, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("read_rdata", bus.rdata, 32'hDEAD_BEEF);

        // Write with error response from requester 2
        c_req     = 4'b0100;
        c_wr[2]   = 1'b1;
        c_dina[2] = 32'd5;
        c_dinb[2] = 32'd7;
        c_sel[2]  = 2'b10;
        drive();
        xfer(1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);

        // Timeout on a read from requester 0
        c_req   = 4'b0001;
        c_wr[0] = 1'b0;
        drive();
        xfer(0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Requester 3 withdraws after grant; ack still pulses
        c_req = 4'b1000;
        drive();
        xfer(1, 1'b0, 1'b0, $urandom, 1'b1, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            c_req = c_req | N'($urandom_range(0, (1 << N) - 1));
            if (c_req == '0) c_req = N'(1) << $urandom_range(0, N - 1);
            drive();
            xfer(int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 $urandom, ($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                c_req = '0;
                drive();
                step();
                chk("gap_busy", 32'(bus.busy), 0);
            end
        end

        // Reset in the middle of WAIT: outputs clear at once, no ack, priority restarts at 0
        c_req = 4'b0100;
        drive();
        step();
        step();
        step();
        chk("prerst_gnt", 32'(bus.gnt), 32'(4'b0100));
        hresetn = 1'b0;
        #1;
        chk_all_zero("midrst");
        step();
        chk("midrst_ack", 32'(bus.ack), 0);
        hresetn   = 1'b1;
        exp_last  = N - 1;
        exp_rdata = '0;
        c_req     = '1;
        drive();
        xfer(0, 1'b0, 1'b0, $urandom, 1'b0, 1'b0);
        chk("postrst_last", 32'(exp_last), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
